sram_bus_ctrl: RTL

Parametrised controller for an asynchronous SRAM that owns the bidirectional data bus. It accepts single-word read and write requests from synchronous logic, sequences CE/OE/WE/byte-enable strobes with configurable wait states, and drives the data bus only during writes. Read data is captured in a register, and byte-lane masking is applied. It sits between Mem2IO-style user logic and the board SRAM pins.

---
 rtl/sram_bus_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sram_bus_ctrl.sv
// Single-word controller for an asynchronous SRAM. It sequences the CE/OE/WE/BE
// strobes with programmable wait states and owns the bidirectional data bus.
module sram_bus_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [BE_W-1:0]   SRAM_BE_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [1:0]        o_dbg_state,
  output logic              o_dbg_dq_oe
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_WR    = 2'd2;
  localparam logic [1:0] ST_WHOLD = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  // Handshake: a request is taken on any rising edge where req and ready are
  // both high; ready is high only in IDLE, and req is ignored otherwise.
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_wdone;

  logic [DATA_W-1:0] w_lane_mask;
  logic              w_dq_oe;
  logic              w_accept;

  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_lane_mask[i*8 +: 8] = {8{r_be[i]}};
    end
  end

  assign w_accept = req && (r_state == ST_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
            r_cnt   <= CNT_LOAD;
            r_state <= we ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (r_cnt == 4'd0) begin
            r_rdata  <= SRAM_DQ & w_lane_mask;
            r_rvalid <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WR: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_WHOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_wdone <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pins decode from registered state only, so they move just after an edge
  // and the bus drive can never overlap an OE_N-low cycle.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_BE_N = '1;
    w_dq_oe   = 1'b0;
    case (r_state)
      ST_RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_BE_N = ~r_be;
      end
      ST_WR: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        SRAM_BE_N = ~r_be;
        w_dq_oe   = 1'b1;
      end
      ST_WHOLD: begin
        SRAM_CE_N = 1'b0;
        SRAM_BE_N = ~r_be;
        w_dq_oe   = 1'b1;
      end
      default: begin
        SRAM_CE_N = 1'b1;
      end
    endcase
  end

  assign SRAM_DQ     = w_dq_oe ? r_wdata : {DATA_W{1'bz}};
  assign SRAM_ADDR   = r_addr;
  assign ready       = (r_state == ST_IDLE);
  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign wdone       = r_wdone;
  assign o_dbg_state = r_state;
  assign o_dbg_dq_oe = w_dq_oe;

endmodule
